stopwatch_ctrl: RTL and testbench

Button-driven control sequencer for the stopwatch datapath. It debounces the start/stop and lap/clear push-buttons and runs a four-state FSM. The FSM produces the count-enable and the synchronous clear for the digit counter chain, and selects live or lap-frozen BCD digits for the seven-segment display. It sits in the 5 MHz domain between the board buttons and the counter and display blocks, and replaces the raw `stop` switch as the run source.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_ctrl_btn_debounce.sv | 63 ++++++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control sequencer.
// Holds the FSM state encoding, the digit bus width and the default debounce length.
package stopwatch_pkg;

    localparam int SW_DIGITS_W        = 16;
    localparam int SW_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_LAP   = 2'b10,
        ST_PAUSE = 2'b11
    } sw_state_t;

    // Counting continues while a lap value is being shown.
    function automatic logic state_counts(input sw_state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse.
// Press pulse appears DEBOUNCE_CYCLES+2 edges after the raw level is first sampled; no backpressure.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic clk_main,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        // The count only survives while the synchronized level keeps disagreeing.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced start/stop and lap/clear buttons drive a 4-state FSM.
// Outputs change DEBOUNCE_CYCLES+3 edges after a held press is first sampled; no backpressure.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
    parameter int DIGITS_W        = SW_DIGITS_W
) (
    input  logic                clk_main,
    input  logic                reset,
    input  logic                btn_start,
    input  logic                btn_lap,
    input  logic [DIGITS_W-1:0] count_bcd,
    output logic                run,
    output logic                clear,
    output logic                lap_active,
    output logic [DIGITS_W-1:0] disp_bcd,
    output logic [1:0]          state
);

    logic       start_press;
    logic       lap_press;
    logic [1:0] levels_unused;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start_db (
        .clk_main(clk_main),
        .reset   (reset),
        .btn     (btn_start),
        .level   (levels_unused[0]),
        .press   (start_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lap_db (
        .clk_main(clk_main),
        .reset   (reset),
        .btn     (btn_lap),
        .level   (levels_unused[1]),
        .press   (lap_press)
    );

    sw_state_t           state_q, state_d;
    logic                run_q, run_d;
    logic                clear_q, clear_d;
    logic                lap_active_q, lap_active_d;
    logic [DIGITS_W-1:0] lap_reg_q, lap_reg_d;

    always_comb begin
        state_d   = state_q;
        clear_d   = 1'b0;
        lap_reg_d = lap_reg_q;
        // Start is tested first everywhere, so a coincident lap press is dropped.
        unique case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d = ST_RUN;
                end else if (lap_press) begin
                    clear_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_press) begin
                    state_d = ST_PAUSE;
                end else if (lap_press) begin
                    lap_reg_d = count_bcd;
                    state_d   = ST_LAP;
                end
            end
            ST_LAP: begin
                if (start_press) begin
                    state_d = ST_PAUSE;
                end else if (lap_press) begin
                    lap_reg_d = count_bcd;
                end
            end
            ST_PAUSE: begin
                if (start_press) begin
                    state_d = ST_RUN;
                end else if (lap_press) begin
                    clear_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        run_d        = state_counts(state_d);
        lap_active_d = (state_d == ST_LAP);
    end

    always_ff @(posedge clk_main or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            clear_q      <= 1'b0;
            lap_active_q <= 1'b0;
            lap_reg_q    <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            clear_q      <= clear_d;
            lap_active_q <= lap_active_d;
            lap_reg_q    <= lap_reg_d;
        end
    end

    assign run        = run_q;
    assign clear      = clear_q;
    assign lap_active = lap_active_q;
    assign state      = state_q;
    assign disp_bcd   = lap_active_q ? lap_reg_q : count_bcd;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: directed table, corner sequences,
// and random button activity compared every cycle against a timeline reference model.
module tb_stopwatch_ctrl;

    localparam int N = 4;

    logic        clk_main = 1'b0;
    logic        reset = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_lap = 1'b0;
    logic [15:0] count_bcd = 16'h0000;
    logic        run;
    logic        clear;
    logic        lap_active;
    logic [15:0] disp_bcd;
    logic [1:0]  state;

    always #5 clk_main = ~clk_main;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .DIGITS_W       (16)
    ) dut (
        .clk_main  (clk_main),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .count_bcd (count_bcd),
        .run       (run),
        .clear     (clear),
        .lap_active(lap_active),
        .disp_bcd  (disp_bcd),
        .state     (state)
    );

    int total = 0;
    int bad   = 0;
    int clear_seen = 0;

    // Reference model: raw samples per edge since reset, and press events scheduled on a timeline.
    int          m_e;
    int          m_state;
    bit          m_clear;
    logic [15:0] m_lap_reg;
    int          m_last [2];
    int          m_due  [2];
    bit          m_lvl  [2];
    bit          h_s [$];
    bit          h_l [$];

    typedef struct {
        logic        s;
        logic        l;
        logic [15:0] cnt;
        logic [1:0]  st;
        logic        run;
        logic        lap;
        logic [15:0] disp;
        int          clears;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit synced(input int b, input int j);
        if (j < 2) return 1'b0;
        return (b == 0) ? h_s[j-2] : h_l[j-2];
    endfunction

    task automatic model_reset();
        m_e       = 0;
        m_state   = 0;
        m_clear   = 1'b0;
        m_lap_reg = 16'h0000;
        for (int b = 0; b < 2; b++) begin
            m_last[b] = -1000;
            m_due[b]  = -1;
            m_lvl[b]  = 1'b0;
        end
        h_s.delete();
        h_l.delete();
    endtask

    task automatic model_step();
        bit s_ev;
        bit l_ev;
        bit all_diff;
        if (!reset) begin
            model_reset();
            return;
        end
        s_ev    = (m_due[0] == m_e);
        l_ev    = (m_due[1] == m_e);
        m_clear = 1'b0;
        if (s_ev) begin
            m_state = (m_state == 1 || m_state == 2) ? 3 : 1;
        end else if (l_ev) begin
            case (m_state)
                0: m_clear = 1'b1;
                1, 2: begin
                    m_lap_reg = count_bcd;
                    m_state   = 2;
                end
                default: begin
                    m_clear = 1'b1;
                    m_state = 0;
                end
            endcase
        end
        h_s.push_back(btn_start);
        h_l.push_back(btn_lap);
        // Level flips once the synchronized input has disagreed for N consecutive edges.
        for (int b = 0; b < 2; b++) begin
            if ((m_e - m_last[b] >= N) && (m_e >= N - 1)) begin
                all_diff = 1'b1;
                for (int j = m_e - N + 1; j <= m_e; j++) begin
                    if (synced(b, j) == m_lvl[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[b]  = !m_lvl[b];
                    m_last[b] = m_e;
                    if (m_lvl[b]) m_due[b] = m_e + 2;
                end
            end
        end
        m_e++;
    endtask

    task automatic tick();
        logic        e_run;
        logic        e_lap;
        logic [15:0] e_disp;
        @(posedge clk_main);
        model_step();
        @(negedge clk_main);
        if (clear) clear_seen++;
        e_run  = (m_state == 1) || (m_state == 2);
        e_lap  = (m_state == 2);
        e_disp = e_lap ? m_lap_reg : count_bcd;
        chk("model", {11'd0, state, run, clear, lap_active, disp_bcd},
            {11'd0, 2'(m_state), e_run, m_clear, e_lap, e_disp});
    endtask

    initial begin
        int rem_s;
        int rem_l;
        tbl[0] = '{1'b0, 1'b1, 16'h0123, 2'b10, 1'b1, 1'b1, 16'h0123, 0};
        tbl[1] = '{1'b0, 1'b1, 16'h0200, 2'b10, 1'b1, 1'b1, 16'h0200, 0};
        tbl[2] = '{1'b1, 1'b0, 16'h0333, 2'b11, 1'b0, 1'b0, 16'h0333, 0};
        tbl[3] = '{1'b0, 1'b1, 16'h0444, 2'b00, 1'b0, 1'b0, 16'h0444, 1};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 1};
        tbl[5] = '{1'b1, 1'b0, 16'h0010, 2'b01, 1'b1, 1'b0, 16'h0010, 0};
        tbl[6] = '{1'b1, 1'b1, 16'h0020, 2'b11, 1'b0, 1'b0, 16'h0020, 0};
        tbl[7] = '{1'b1, 1'b0, 16'h0030, 2'b01, 1'b1, 1'b0, 16'h0030, 0};
        tbl[8] = '{1'b0, 1'b1, 16'h0040, 2'b10, 1'b1, 1'b1, 16'h0040, 0};

        model_reset();
        count_bcd = 16'h0abc;
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_clear", 32'(clear), 32'd0);
        chk("rst_lap_active", 32'(lap_active), 32'd0);
        chk("rst_disp", 32'(disp_bcd), 32'h0abc);
        reset     = 1'b1;
        count_bcd = 16'h0000;

        // Press latency: held start lands on edge 7, not before, and only once.
        btn_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 6) chk("latency_edge6", {30'd0, state}, 32'd0);
            if (i == 7) chk("latency_edge7", {29'd0, state, run}, {29'd0, 2'b01, 1'b1});
        end
        btn_start = 1'b0;
        repeat (10) tick();
        chk("held_single_run", {29'd0, state, run}, {29'd0, 2'b01, 1'b1});

        for (int k = 0; k < 9; k++) begin
            btn_start  = tbl[k].s;
            btn_lap    = tbl[k].l;
            count_bcd  = tbl[k].cnt;
            clear_seen = 0;
            repeat (8) tick();
            btn_start = 1'b0;
            btn_lap   = 1'b0;
            repeat (8) tick();
            chk($sformatf("tbl%0d_state", k), 32'(state), 32'(tbl[k].st));
            chk($sformatf("tbl%0d_run", k), 32'(run), 32'(tbl[k].run));
            chk($sformatf("tbl%0d_lap_active", k), 32'(lap_active), 32'(tbl[k].lap));
            chk($sformatf("tbl%0d_disp", k), 32'(disp_bcd), 32'(tbl[k].disp));
            chk($sformatf("tbl%0d_clears", k), 32'(clear_seen), 32'(tbl[k].clears));
            if (k == 0) begin
                count_bcd = 16'h0150;
                repeat (3) tick();
                chk("lap_frozen_disp", 32'(disp_bcd), 32'h0123);
                chk("lap_still_run", 32'(run), 32'd1);
            end
            if (k == 6) chk("both_lap_reg_kept", 32'(dut.lap_reg_q), 32'h0200);
        end

        // Async reset from LAP with the start debounce mid-count, start held through release.
        btn_start = 1'b1;
        repeat (3) tick();
        count_bcd = 16'h0777;
        #2;
        chk("pre_reset_frozen", 32'(disp_bcd), 32'h0040);
        reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_run", 32'(run), 32'd0);
        chk("async_rst_clear", 32'(clear), 32'd0);
        chk("async_rst_lap_active", 32'(lap_active), 32'd0);
        chk("async_rst_disp", 32'(disp_bcd), 32'h0777);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 6) chk("rel_edge6", {29'd0, state, run}, 32'd0);
            if (i == 7) chk("rel_edge7", {29'd0, state, run}, {29'd0, 2'b01, 1'b1});
        end
        btn_start = 1'b0;
        repeat (8) tick();

        // Glitch rejection from IDLE: 3-cycle pulses never qualify.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int r = 0; r < 10; r++) begin
            btn_start = 1'b1;
            repeat (3) tick();
            btn_start = 1'b0;
            repeat (3) tick();
        end
        repeat (8) tick();
        chk("glitch_state", 32'(state), 32'd0);
        chk("glitch_run", 32'(run), 32'd0);

        rem_s = 0;
        rem_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rem_s == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                rem_s     = $urandom_range(1, 9);
            end
            if (rem_l == 0) begin
                btn_lap = 1'($urandom_range(0, 1));
                rem_l   = $urandom_range(1, 9);
            end
            rem_s--;
            rem_l--;
            count_bcd = 16'($urandom);
            reset     = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
